// File: rtl/fp32_key_decode_stream.sv
// Streaming decoder from order-preserving sortable keys back to IEEE-754 binary32, with class flags and per-frame stats.
// Optional CANON_NAN_EN: replace every decoded NaN by the canonical quiet NaN 0x7FC00000.
module fp32_key_decode_stream #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_key,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_fp,
  output logic             out_last,
  output logic             out_is_nan,
  output logic             out_is_inf,
  output logic             out_is_zero,
  output logic             out_is_denorm,
  output logic             stat_valid,
  output logic [CNT_W-1:0] stat_nan_cnt,
  output logic [CNT_W-1:0] stat_zero_cnt,
  output logic [CNT_W-1:0] stat_inf_cnt
);

  localparam int unsigned     DW        = 32;
  localparam logic [DW-1:0]   SIGN_MASK = 32'h8000_0000;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
`ifdef CANON_NAN_EN
  localparam logic [DW-1:0]   CANON_NAN = 32'h7FC0_0000;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != CNT_MAX)) return c + CNT_W'(1);
    return c;
  endfunction

  logic             s1_v_q, s1_v_d, s1_last_q, s1_last_d;
  logic [DW-1:0]    s1_fp_q, s1_fp_d;
  logic             s2_v_q, s2_v_d, s2_last_q, s2_last_d;
  logic [DW-1:0]    s2_fp_q, s2_fp_d;
  logic             s2_nan_q, s2_nan_d, s2_inf_q, s2_inf_d;
  logic             s2_zero_q, s2_zero_d, s2_den_q, s2_den_d;
  logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d, zero_cnt_q, zero_cnt_d, inf_cnt_q, inf_cnt_d;
  logic [CNT_W-1:0] st_nan_q, st_nan_d, st_zero_q, st_zero_d, st_inf_q, st_inf_d;
  logic             st_valid_q, st_valid_d;

  logic             s1_adv_c, s2_adv_c, out_hs_c;
  logic [DW-1:0]    key_dec_c, s2_fp_c;
  logic             exp_ones_c, exp_zero_c, man_zero_c;
  logic             nan_c, inf_c, zero_c, den_c;
  logic [CNT_W-1:0] nan_sum_c, zero_sum_c, inf_sum_c;

  // Advance conditions; an empty S2 always accepts so bubbles collapse.
  always_comb begin
    s2_adv_c = !s2_v_q || out_ready;
    s1_adv_c = !s1_v_q || s2_adv_c;
    out_hs_c = s2_v_q && out_ready;
  end

  assign in_ready = s1_adv_c;

  // Positive keys carry a set MSB (flip sign back); negative keys were fully inverted.
  always_comb begin
    key_dec_c  = in_key[31] ? (in_key ^ SIGN_MASK) : ~in_key;
    exp_ones_c = &s1_fp_q[30:23];
    exp_zero_c = ~|s1_fp_q[30:23];
    man_zero_c = ~|s1_fp_q[22:0];
    nan_c      = exp_ones_c && !man_zero_c;
    inf_c      = exp_ones_c && man_zero_c;
    zero_c     = exp_zero_c && man_zero_c;
    den_c      = exp_zero_c && !man_zero_c;
`ifdef CANON_NAN_EN
    s2_fp_c    = nan_c ? CANON_NAN : s1_fp_q;
`else
    s2_fp_c    = s1_fp_q;
`endif
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_fp_d   = s1_fp_q;
    s1_last_d = s1_last_q;
    s2_v_d    = s2_v_q;
    s2_fp_d   = s2_fp_q;
    s2_last_d = s2_last_q;
    s2_nan_d  = s2_nan_q;
    s2_inf_d  = s2_inf_q;
    s2_zero_d = s2_zero_q;
    s2_den_d  = s2_den_q;
    if (s1_adv_c) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_fp_d   = key_dec_c;
        s1_last_d = in_last;
      end
    end
    if (s2_adv_c) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_fp_d   = s2_fp_c;
        s2_last_d = s1_last_q;
        s2_nan_d  = nan_c;
        s2_inf_d  = inf_c;
        s2_zero_d = zero_c;
        s2_den_d  = den_c;
      end
    end
  end

  // Counters include the current output beat; a frame end publishes totals and restarts.
  always_comb begin
    nan_sum_c  = sat_inc(nan_cnt_q,  out_hs_c && s2_nan_q);
    zero_sum_c = sat_inc(zero_cnt_q, out_hs_c && s2_zero_q);
    inf_sum_c  = sat_inc(inf_cnt_q,  out_hs_c && s2_inf_q);
    nan_cnt_d  = nan_sum_c;
    zero_cnt_d = zero_sum_c;
    inf_cnt_d  = inf_sum_c;
    st_nan_d   = st_nan_q;
    st_zero_d  = st_zero_q;
    st_inf_d   = st_inf_q;
    st_valid_d = 1'b0;
    if (out_hs_c && s2_last_q) begin
      st_valid_d = 1'b1;
      st_nan_d   = nan_sum_c;
      st_zero_d  = zero_sum_c;
      st_inf_d   = inf_sum_c;
      nan_cnt_d  = '0;
      zero_cnt_d = '0;
      inf_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_fp_q    <= '0;
      s1_last_q  <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_fp_q    <= '0;
      s2_last_q  <= 1'b0;
      s2_nan_q   <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_den_q   <= 1'b0;
      nan_cnt_q  <= '0;
      zero_cnt_q <= '0;
      inf_cnt_q  <= '0;
      st_nan_q   <= '0;
      st_zero_q  <= '0;
      st_inf_q   <= '0;
      st_valid_q <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_fp_q    <= s1_fp_d;
      s1_last_q  <= s1_last_d;
      s2_v_q     <= s2_v_d;
      s2_fp_q    <= s2_fp_d;
      s2_last_q  <= s2_last_d;
      s2_nan_q   <= s2_nan_d;
      s2_inf_q   <= s2_inf_d;
      s2_zero_q  <= s2_zero_d;
      s2_den_q   <= s2_den_d;
      nan_cnt_q  <= nan_cnt_d;
      zero_cnt_q <= zero_cnt_d;
      inf_cnt_q  <= inf_cnt_d;
      st_nan_q   <= st_nan_d;
      st_zero_q  <= st_zero_d;
      st_inf_q   <= st_inf_d;
      st_valid_q <= st_valid_d;
    end
  end

  assign out_valid     = s2_v_q;
  assign out_fp        = s2_fp_q;
  assign out_last      = s2_last_q;
  assign out_is_nan    = s2_nan_q;
  assign out_is_inf    = s2_inf_q;
  assign out_is_zero   = s2_zero_q;
  assign out_is_denorm = s2_den_q;
  assign stat_valid    = st_valid_q;
  assign stat_nan_cnt  = st_nan_q;
  assign stat_zero_cnt = st_zero_q;
  assign stat_inf_cnt  = st_inf_q;

endmodule

// File: doc/fp32_key_decode_stream.md
Name: fp32_key_decode_stream

Overview:
- Streaming inverse of the fp32 order-preserving key mapping. Takes sortable 32-bit keys produced upstream (e.g. after key-domain max/min or sorting) and returns IEEE-754 binary32 values with class flags.
- Two-stage valid/ready pipeline with per-frame class statistics.
- Sits at the output of key-domain compare/sort datapaths, restoring floats before they are written back.

Parameters:
CNT_W, 16, width of each per-frame saturating statistic counter (legal 4..32)

Ports:
clk  input  1  single clock, all logic rising-edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  input key beat valid
in_ready  output  1  block can accept a key this cycle
in_key  input  32  sortable key
in_last  input  1  final beat of frame
out_valid  output  1  decoded beat valid
out_ready  input  1  downstream accepts beat
out_fp  output  32  decoded fp32 value
out_last  output  1  in_last carried with beat
out_is_nan  output  1  exp==0xFF, mantissa!=0
out_is_inf  output  1  exp==0xFF, mantissa==0
out_is_zero  output  1  exp==0, mantissa==0 (either sign)
out_is_denorm  output  1  exp==0, mantissa!=0
stat_valid  output  1  one-cycle pulse: frame statistics valid
stat_nan_cnt  output  CNT_W  NaN beats in finished frame
stat_zero_cnt  output  CNT_W  zero beats in finished frame
stat_inf_cnt  output  CNT_W  inf beats in finished frame

Behaviour:
- Decode rule: key[31]==1 -> fp = key ^ 0x80000000; key[31]==0 -> fp = ~key. Exact bit inverse of encode (positive: flip sign bit; negative: invert all bits). Signed zeros preserved: key 0x80000000 -> 0x00000000, key 0x7FFFFFFF -> 0x80000000.
- Pipeline: S1 registers the decoded value plus last. S2 registers the value, last and class flags and drives the out_* ports.
- Latency: 2 cycles from input handshake to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Advance rules:
  - s2_adv = !s2_v | out_ready
  - s1_adv = !s1_v | s2_adv
  - in_ready = s1_adv, combinational from registered state and out_ready.
  - Bubbles collapse: an empty S2 loads from S1 even while out_ready=0.
- While out_valid=1 and out_ready=0, every out_* bit is held stable. No beat is dropped or duplicated.
- Handshake occurs when valid & ready are both high in the same cycle. A beat presented with in_valid=1 and in_ready=0 must be held by upstream.
- Statistics:
  - Counters increment on each output handshake for the matching class flag.
  - Counters saturate at 2^CNT_W-1, no wrap.
  - On an output handshake with out_last=1:
    - Next cycle, stat_valid=1 for exactly one cycle.
    - stat_*_cnt carry totals including that last beat.
    - Internal counters restart at 0, or at 1 for the class of a beat handshaked in that same next cycle.
  - stat_*_cnt hold their value until the next frame end.
- Back-to-back frames: consecutive last beats produce consecutive stat_valid pulses, each with correct independent counts.
- Single-beat frame (in_last on the first beat) produces a stat pulse with counts of that beat only.
- Reset (rst_n=0 at a clock edge), including mid-frame:
  - s1_v, s2_v, out_valid, stat_valid = 0.
  - Counters, stat_*_cnt, out_fp and flags = 0.
  - in_ready=1 on the first cycle after reset deasserts.
  - The partial frame is discarded; no stat pulse is emitted for it.

Optional Feature:
CANON_NAN_EN
- Defined: any decoded NaN is replaced in S2 by canonical 0x7FC00000, sign and payload discarded; out_is_nan is still 1 and it still counts as NaN.
- Undefined: NaN bit pattern passes through exactly per the decode rule (key 0x003FFFFF -> 0xFFC00000).
- Other values are unaffected either way.

Test Plan:
1. Keys 0x80000000, 0x7FFFFFFF, 0xBF800000, 0x407FFFFF, out_ready=1 -> out_fp 0x00000000, 0x80000000, 0x3F800000, 0xBF800000, appearing 2 cycles after each input. out_is_zero=1 on the first two beats only.
2. Frame of 5 beats: keys 0xFF800000 (+inf), 0x007FFFFF (-inf), 0xFFC00001 (NaN), 0x80000000, 0x80000001 (denorm 0x00000001) with last on beat 5 -> one stat_valid pulse: nan=1, zero=1, inf=2. out_is_denorm=1 on beat 5.
3. Backpressure:
   - out_ready=0 for 6 cycles while streaming 4 keys -> in_ready drops after 2 accepted beats.
   - out_fp is held constant throughout.
   - After out_ready=1, all 4 beats emerge in order with no loss or duplication.
4. rst_n=0 for 1 cycle mid-frame after 3 beats -> outputs and counters are 0 and no stat pulse. The next 2-beat frame reports counts of only those 2 beats.
5. CANON_NAN_EN defined vs undefined, key 0x003FFFFF -> out_fp 0x7FC00000 vs 0xFFC00000. out_is_nan=1 in both cases.
6. CNT_W=4, frame of 20 zero keys (0x80000000) -> stat_zero_cnt=15 (saturated). Random 10k keys checked against decode(encode(x))==x with random in_valid/out_ready.
